sw_debounce: RTL and testbench

- Input-conditioning stage that sits directly upstream of the switch priority encoder / 7-seg driver.
- Synchronises the 8 raw board switches into the clk domain and debounces each bit independently.
- Presents a clean, glitch-free `sw_db` vector to the encoder, plus a one-cycle change strobe and a per-bit change mask for downstream logging or LED effects.

---
 rtl/sw_debounce_pkg.sv | 14 +
 rtl/sw_debounce_db_bit.sv | 68 ++++++
 rtl/sw_debounce.sv | 63 ++++++
 tb/tb_sw_debounce.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// -----------------------------------------------------------------------------
// sw_debounce_pkg
// Shared constants for the board-switch input conditioning path.
//   SW_WIDTH        : number of physical slide switches on the board
//   DB_CYCLES_SIM   : short debounce window used in simulation
//   DB_CYCLES_BOARD : debounce window for a 50 MHz board build (20 ms)
// -----------------------------------------------------------------------------
package sw_debounce_pkg;

    localparam int SW_WIDTH        = 8;
    localparam int DB_CYCLES_SIM   = 4;
    localparam int DB_CYCLES_BOARD = 1_000_000;

endpackage : sw_debounce_pkg

// File: rtl/sw_debounce_db_bit.sv
// -----------------------------------------------------------------------------
// sw_debounce_db_bit
// One switch bit: 2-FF synchronizer, stability counter and debounced flop.
// Ports:
//   clk_i  : system clock
//   rst_i  : synchronous, active-high reset
//   raw_i  : asynchronous switch level from the pin
//   db_o   : debounced level (registered)
//   chg_o  : combinational "db_o changes at this edge" flag; the parent
//            registers it so its change outputs line up with db_o
// -----------------------------------------------------------------------------
module sw_debounce_db_bit #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic db_o,
    output logic chg_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             differ;
    logic             at_last;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    always_comb begin
        differ  = (sync2_q != db_q);
        at_last = (cnt_q == CNT_LAST);
        chg_o   = differ && at_last;
        cnt_d   = '0;
        db_d    = db_q;
        // Any sample matching the current debounced level restarts the count;
        // the count also restarts on the qualifying edge, so it never wraps.
        if (differ) begin
            if (at_last) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db_o = db_q;

endmodule : sw_debounce_db_bit

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
// Synchronises and debounces the raw board switches, bit by bit, and reports
// which bits of the clean vector changed.
// Ports:
//   clk      : system clock, single domain
//   rst      : synchronous, active-high reset
//   sw_raw   : asynchronous switch levels from the pins
//   sw_db    : debounced switch vector (to the priority encoder)
//   sw_chg   : one-cycle pulse in the cycle sw_db takes a new value
//   chg_mask : bits of sw_db that changed with that pulse, 0 otherwise
// Interface: no handshake. sw_db is a level that consumers may sample every
// cycle; sw_chg/chg_mask are informational and cannot be stalled.
// -----------------------------------------------------------------------------
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH     = SW_WIDTH,
    parameter int DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic             sw_chg,
    output logic [WIDTH-1:0] chg_mask
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic [WIDTH-1:0] chg_flags;
    logic [WIDTH-1:0] chg_mask_q;
    logic             sw_chg_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_db_bit #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_bit (
            .clk_i (clk),
            .rst_i (rst),
            .raw_i (sw_raw[i]),
            .db_o  (sw_db[i]),
            .chg_o (chg_flags[i])
        );
    end

    // Registered on the same edge the bit flops update, so the pulse and
    // mask are visible in the same cycle as the new sw_db value.
    always_ff @(posedge clk) begin
        if (rst) begin
            chg_mask_q <= '0;
            sw_chg_q   <= 1'b0;
        end else begin
            chg_mask_q <= chg_flags;
            sw_chg_q   <= |chg_flags;
        end
    end

    assign chg_mask = chg_mask_q;
    assign sw_chg   = sw_chg_q;

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
// -----------------------------------------------------------------------------
// tb_sw_debounce
// Directed plus randomised stimulus for sw_debounce with DB_CYCLES=4. The
// reference model keeps a history of the levels presented at each edge and
// decides, per bit, whether the last DB_CYCLES synchronised samples all
// differed from the debounced level with no reset or update inside that
// window.
// -----------------------------------------------------------------------------
module tb_sw_debounce;

    localparam int W    = 8;
    localparam int DB   = 4;
    localparam int MAXE = 4096;

    logic         clk;
    logic         rst;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_db;
    logic         sw_chg;
    logic [W-1:0] chg_mask;

    sw_debounce #(
        .WIDTH     (W),
        .DB_CYCLES (DB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_raw   (sw_raw),
        .sw_db    (sw_db),
        .sw_chg   (sw_chg),
        .chg_mask (chg_mask)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [W-1:0] raw_hist [0:MAXE-1];
    int           last_evt [W];
    int           last_rst;
    int           edge_n;
    logic [W-1:0] m_db;
    logic [W-1:0] m_mask;
    logic         m_chg;

    int checks;
    int errors;
    int pulses;

    // Synchronised sample seen by the debouncer at edge j: the level presented
    // two edges earlier, or 0 if a reset intervened.
    function automatic logic sample_at(input int j, input int b);
        int idx;
        idx = j - 2;
        if (idx > last_rst) return raw_hist[idx][b];
        return 1'b0;
    endfunction

    task automatic model_edge(input logic [W-1:0] raw, input logic r);
        logic [W-1:0] upd;
        logic         ok;
        edge_n++;
        raw_hist[edge_n] = raw;
        if (r) begin
            m_db     = '0;
            m_mask   = '0;
            last_rst = edge_n;
            for (int b = 0; b < W; b++) last_evt[b] = edge_n;
        end else begin
            upd = '0;
            for (int b = 0; b < W; b++) begin
                if (edge_n - last_evt[b] >= DB) begin
                    ok = 1'b1;
                    for (int j = edge_n - DB + 1; j <= edge_n; j++)
                        if (sample_at(j, b) == m_db[b]) ok = 1'b0;
                    upd[b] = ok;
                end
            end
            for (int b = 0; b < W; b++)
                if (upd[b]) last_evt[b] = edge_n;
            m_db   = m_db ^ upd;
            m_mask = upd;
        end
        m_chg = |m_mask;
    endtask

    task automatic check_outputs();
        checks++;
        assert (sw_db === m_db) else begin
            errors++;
            $error("FAIL sw_db edge %0d: got %h want %h", edge_n, sw_db, m_db);
        end
        checks++;
        assert (sw_chg === m_chg) else begin
            errors++;
            $error("FAIL sw_chg edge %0d: got %b want %b", edge_n, sw_chg, m_chg);
        end
        checks++;
        assert (chg_mask === m_mask) else begin
            errors++;
            $error("FAIL chg_mask edge %0d: got %h want %h", edge_n, chg_mask, m_mask);
        end
    endtask

    // driver: apply inputs away from the edge, then compare after it
    task automatic step(input logic [W-1:0] raw, input logic r);
        @(negedge clk);
        sw_raw = raw;
        rst    = r;
        @(posedge clk);
        model_edge(raw, r);
        #1;
        check_outputs();
        if (sw_chg === 1'b1) pulses++;
    endtask

    task automatic hold(input logic [W-1:0] raw, input int n);
        for (int i = 0; i < n; i++) step(raw, 1'b0);
    endtask

    task automatic check_pulses(input string tag, input int want);
        checks++;
        assert (pulses == want) else begin
            errors++;
            $error("FAIL %s: pulse count %0d want %0d", tag, pulses, want);
        end
    endtask

    logic [W-1:0] cur;

    initial begin
        checks   = 0;
        errors   = 0;
        pulses   = 0;
        edge_n   = 0;
        last_rst = 0;
        m_db     = '0;
        m_mask   = '0;
        m_chg    = 1'b0;
        for (int b = 0; b < W; b++) last_evt[b] = 0;
        sw_raw   = '0;
        rst      = 1'b1;

        // reset with switches already on
        step(8'hFF, 1'b1);
        step(8'hFF, 1'b1);
        hold(8'hFF, 10);
        hold(8'h00, 10);

        // multi-bit change
        hold(8'h05, 10);
        hold(8'h00, 10);

        // short glitch on bit 3 must be rejected
        pulses = 0;
        hold(8'h08, 3);
        hold(8'h00, 8);
        check_pulses("glitch_bit3", 0);

        // bounce on bit 7 then settle high: a single pulse
        pulses = 0;
        step(8'h80, 1'b0);
        step(8'h00, 1'b0);
        step(8'h80, 1'b0);
        step(8'h80, 1'b0);
        step(8'h00, 1'b0);
        hold(8'h80, 10);
        check_pulses("bounce_bit7", 1);
        hold(8'h00, 10);

        // staggered bits: back-to-back pulses
        pulses = 0;
        step(8'h01, 1'b0);
        hold(8'h03, 10);
        check_pulses("staggered", 2);
        hold(8'h00, 10);

        // reset while bit 2 is mid-count
        hold(8'h04, 4);
        step(8'h04, 1'b1);
        hold(8'h04, 10);
        hold(8'h00, 10);

        // randomised: mostly holds, occasional new values, bursts and resets
        cur = '0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) cur = W'($urandom);
            if ($urandom_range(0, 9) == 0)
                step(cur ^ W'($urandom), 1'b0);
            else
                step(cur, ($urandom_range(0, 149) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sw_debounce
